// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the core's single shared memory port between the
// instruction-fetch requester and the data requester. One transaction is in
// flight at a time; completions re-arbitrate in the same cycle so that mem_req
// can stay high across consecutive transactions.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_ack,
  // Data requester
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  // Shared return path and pipeline stalls
  output logic [31:0]       rdata,
  output logic              i_stall,
  output logic              d_stall,
  // Memory interface
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  // Status
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  // The wait counter expires when it would step onto TIMEOUT, so a transaction
  // is allowed exactly TIMEOUT cycles of mem_req before being abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              last_d_q, last_d_d;
  logic              drop_q, drop_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              busy;
  logic              done;
  logic              expire;
  logic              arb_en;
  logic              i_elig;
  logic              pick_d;
  logic              pick_i;

  // Decode completion and timeout of the transaction currently in flight.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default at
    // the top, otherwise a missed branch would infer a latch.
    busy   = 1'b0;
    done   = 1'b0;
    expire = 1'b0;
    busy   = (state_q != IDLE);
    done   = busy & mem_ready;
    // mem_ready in the expiry cycle wins over the timeout.
    expire = busy & ~mem_ready & (cnt_q == CNT_LAST);
  end

  // Choose the next transaction; uses last_d as updated by a completion in
  // this same cycle, so a finishing data access hands the port to a waiting fetch.
  always_comb begin
    last_d_d = last_d_q;
    i_elig   = 1'b0;
    arb_en   = 1'b0;
    pick_d   = 1'b0;
    pick_i   = 1'b0;
    if (done) begin
      last_d_d = (state_q == DATA);
    end
    i_elig = i_req & ~i_flush;
    arb_en = (state_q == IDLE) | done;
    pick_d = d_req & (~i_elig | ~last_d_d);
    pick_i = i_elig & ~pick_d;
  end

  // Next-state logic: timeout abandon, launch/relaunch, or wait-cycle bookkeeping.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    if (expire) begin
      // Abandon without ack; arbitration resumes from IDLE next cycle.
      state_d   = IDLE;
      mem_req_d = 1'b0;
      drop_d    = 1'b0;
      err_d     = 1'b1;
    end else if (arb_en) begin
      // Any completion retires a pending drop of a flushed fetch.
      drop_d = 1'b0;
      if (pick_d) begin
        state_d     = DATA;
        mem_req_d   = 1'b1;
        mem_addr_d  = d_addr;
        mem_we_d    = d_we;
        mem_wdata_d = d_wdata;
        cnt_d       = '0;
      end else if (pick_i) begin
        state_d     = FETCH;
        mem_req_d   = 1'b1;
        mem_addr_d  = i_addr;
        mem_we_d    = 4'b0000;
        mem_wdata_d = '0;
        cnt_d       = '0;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end else if (busy) begin
      cnt_d = cnt_q + 16'd1;
      // A redirect during a fetch lets the access finish but suppresses its ack.
      if ((state_q == FETCH) && i_flush) begin
        drop_d = 1'b1;
      end
    end
  end

  // State and memory-interface registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      last_d_q    <= 1'b0;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      last_d_q    <= last_d_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Acks are combinational from the registered state and mem_ready; the two
  // states are exclusive so the acks can never coincide.
  assign i_ack = (state_q == FETCH) & mem_ready & ~drop_q & ~i_flush;
  assign d_ack = (state_q == DATA) & mem_ready;

  // Stalls and read data are forced low while reset is asserted.
  assign i_stall = rst_n & i_req & ~i_ack;
  assign d_stall = rst_n & d_req & ~d_ack;
  assign rdata   = mem_rdata & {32{rst_n}};

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign err_timeout = err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller for the core's single shared memory port. It arbitrates between the instruction-fetch requester (IF stage) and the data requester (MEM stage, driven by the decoded store byte-mask and load signals), launches one transaction at a time on a ready-handshaked memory interface, and returns completion pulses and per-stage stall signals to the pipeline. It sits between the pipeline segment registers and the unified instruction/data memory.

## Interface

Parameters:
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 255: maximum cycles a launched transaction may wait for `mem_ready`. Legal range is 1..65535.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `i_req`, input, 1: fetch request. Held high until `i_ack` or `i_flush`.
- `i_addr`, input, ADDR_W: fetch address.
- `i_flush`, input, 1: a branch or jump redirect. Cancels any pending or in-flight fetch.
- `i_ack`, output, 1: one-cycle pulse. Fetch data is valid on `rdata`.
- `d_req`, input, 1: data request. Held high until `d_ack`.
- `d_addr`, input, ADDR_W: data address.
- `d_we`, input, 4: byte write mask. 0000 means load.
- `d_wdata`, input, 32: store data.
- `d_ack`, output, 1: one-cycle pulse. For a load, data is valid on `rdata`.
- `rdata`, output, 32: combinational pass-through of `mem_rdata`.
- `i_stall`, output, 1: equals `i_req & ~i_ack`.
- `d_stall`, output, 1: equals `d_req & ~d_ack`.
- `mem_req`, output, 1: registered transaction-valid signal.
- `mem_addr`, output, ADDR_W: registered address.
- `mem_we`, output, 4: registered byte mask. It is 0000 for every fetch.
- `mem_wdata`, output, 32: registered write data.
- `mem_ready`, input, 1: completion strobe, sampled while `mem_req` is high.
- `err_timeout`, output, 1: sticky flag that a transaction timed out.

## Operation

States:
- `IDLE`: no transaction in flight.
- `FETCH`: a fetch is in flight.
- `DATA`: a data access is in flight.

Register `last_d` is 1 when the most recent completed transaction was a data access.

Arbitration, evaluated in `IDLE`, or in `FETCH`/`DATA` in the cycle `mem_ready` is seen:
- A fetch request is eligible when `i_req & ~i_flush`.
- If only one requester is eligible, it wins.
- If both are eligible, data wins unless `last_d` is 1; in that case fetch wins. Two data accesses therefore never complete back-to-back while a fetch is waiting, which rules out starvation.
- The winner's address, mask and wdata are latched into the `mem_*` registers, and `mem_req` is set to 1 at the next edge.
- If neither requester is eligible, `mem_req` is set to 0 and the state goes to `IDLE`.

Completion:
- In `FETCH` with `mem_ready` high: `i_ack` is 1 in that cycle unless the drop flag is set or `i_flush` is high.
- In `DATA` with `mem_ready` high: `d_ack` is 1 in that cycle.
- In both cases `last_d` is updated and re-arbitration happens in the same cycle (back-to-back launch).

Flush:
- `i_flush` while in `FETCH` sets the drop flag. The transaction continues until `mem_ready`, then completes with no `i_ack`. The drop flag is cleared at that completion.
- `i_flush` never affects `DATA`.

Timeout:
- A 16-bit counter is cleared at each launch and increments each cycle that `mem_req` is high and `mem_ready` is low.
- When the counter reaches `TIMEOUT`:
  - `err_timeout` is set to 1.
  - The transaction is abandoned with no ack, and the state returns to `IDLE` with `mem_req` low.
  - Arbitration resumes in the following cycle.
- If `mem_ready` and the timeout occur in the same cycle, `mem_ready` wins: normal completion, no error.

Reset:
- Asserting `rst_n` low forces immediately, asynchronously: state `IDLE`, `mem_req` 0, `mem_addr`, `mem_we` and `mem_wdata` 0, `last_d` 0, drop flag 0, counter 0, `err_timeout` 0.
- Any in-flight transaction is abandoned and no ack is issued.
- All outputs are 0 during reset.

## Timing

- Launch latency: a request seen in `IDLE` at edge t produces `mem_req` high from edge t+1.
- Minimum transaction time:
  - With `mem_ready` high in the first `mem_req` cycle, the ack occurs in cycle t+1.
  - The requester therefore observes exactly 1 stall cycle.
- Back-to-back throughput is one transaction per `mem_ready`. `mem_req` stays high across consecutive transactions, with no idle bubble.
- `i_ack`, `d_ack`, `rdata`, `i_stall` and `d_stall` are combinational from the registered state and `mem_ready`. The acks are never high in the same cycle.
- The `mem_*` outputs are stable for the whole time `mem_req` is high.
- Requests must stay stable while stalled. A request that changes before its ack is undefined.

## Test plan

1. Reset with `mem_ready` tied to 1 and `i_req`=1 at `i_addr`=0x0000_0000, no `d_req`: `mem_req` rises 1 cycle after reset release, then one `i_ack` per cycle with `mem_we`=0000.
2. `d_req`=1, `d_we`=0011, `d_addr`=0x100, `d_wdata`=0xABCD_1234, with `i_req`=1 simultaneously from `IDLE`, `mem_ready` after 3 wait cycles: data is launched first, `d_ack` after 4 `mem_req` cycles, then fetch launches back-to-back and is acked next.
3. `d_req` and `i_req` both held continuously with `mem_ready`=1: acks alternate d, i, d, i; no two consecutive `d_ack` pulses.
4. Fetch in flight, `i_flush` pulsed in cycle 2, `mem_ready` in cycle 5: no `i_ack`, drop flag clears, and the next fetch with the new address launches in the same cycle as the `mem_ready`.
5. `TIMEOUT`=4, `mem_ready` held at 0: `err_timeout` sets after 4 `mem_req` cycles, `mem_req` drops, no ack, then re-arbitration. Repeat with `mem_ready` arriving exactly at cycle 4: normal ack and `err_timeout` stays 0.
6. `rst_n` driven low mid-`DATA` transaction: `mem_req`, acks and stalls drop immediately without waiting for a clock edge, and after release the first launch follows the step 1 timing.
